// File: rtl/arrow_scheduler.sv
// Frame-timed chart player: steps through a CHART_DEPTH-entry chart, waits each entry's frame delay,
// then pulses the entry's lane mask on launch_o. Optional macro ARROW_SCHEDULER_LOOP_EN wraps the chart.
module arrow_scheduler #(
  parameter int CHART_DEPTH = 16,
  parameter int DELAYW      = 8,
  localparam int AW         = $clog2(CHART_DEPTH),
  localparam int EW         = DELAYW + 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          frame_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [EW-1:0] wr_data_i,
  output logic [3:0]    launch_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] idx_o,
  output logic [2:0]    state_dbg_o
);

  // All controls are single-cycle strobes sampled on the rising edge; there is no
  // back-pressure, and launch_o is a one-cycle pulse the consumer must take as it comes.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    FIRE  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DELAYW-1:0]   cnt_q, cnt_d;
  logic [3:0]          mask_q, mask_d;
  logic                done_q, done_d;
  logic                eoc;
  logic [EW-1:0]       rd_q;
  logic [EW-1:0]       chart_mem [CHART_DEPTH];

  // Memory has no reset so the chart survives rst_i; the read uses the pre-write value.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) chart_mem[wr_addr_i] <= wr_data_i;
    rd_q <= chart_mem[idx_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    done_d  = done_q;
    eoc     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          idx_d   = '0;
          done_d  = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (rd_q == '0) begin
          eoc = 1'b1;
        end else begin
          mask_d = rd_q[3:0];
          if (rd_q[EW-1:4] == '0) begin
            state_d = FIRE;
          end else begin
            cnt_d   = rd_q[EW-1:4];
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (frame_i) begin
          cnt_d = cnt_q - DELAYW'(1);
          if (cnt_q == DELAYW'(1)) state_d = FIRE;
        end
      end
      FIRE: begin
        if (idx_q == AW'(CHART_DEPTH - 1)) begin
          eoc = 1'b1;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ARROW_SCHEDULER_LOOP_EN
    // Wrap to entry 0 unless entry 0 is itself the end marker, which would spin forever.
    if (eoc && idx_q != '0) begin
      idx_d   = '0;
      state_d = FETCH;
    end else if (eoc) begin
      done_d  = 1'b1;
      state_d = DONE;
    end
`else
    if (eoc) begin
      done_d  = 1'b1;
      state_d = DONE;
    end
`endif

    if (stop_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign launch_o    = (state_q == FIRE) ? mask_q : 4'b0000;
  assign busy_o      = (state_q == FETCH) || (state_q == LOAD) ||
                       (state_q == WAIT)  || (state_q == FIRE);
  assign done_o      = done_q;
  assign idx_o       = idx_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Bench for arrow_scheduler: randomized charts and frame pulses against a launch-timeline model
// computed from the chart, the frame pulse table and the per-entry timing rules.
module tb_arrow_scheduler;

  localparam int DEPTH = 16;
  localparam int W     = 24;  // {cycle[15:0], idx[3:0], mask[3:0]}

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        frame_i, start_i, stop_i, wr_en_i;
  logic [3:0]  wr_addr_i;
  logic [11:0] wr_data_i;
  logic [3:0]  launch_o;
  logic        busy_o, done_o;
  logic [3:0]  idx_o;
  logic [2:0]  state_dbg_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0]  chart_m [DEPTH];
  logic         frame_tab [0:511];
  logic [W-1:0] exp_q[$];

  arrow_scheduler #(.CHART_DEPTH(DEPTH), .DELAYW(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_i(frame_i), .start_i(start_i), .stop_i(stop_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .launch_o(launch_o), .busy_o(busy_o), .done_o(done_o), .idx_o(idx_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int addr, input logic [11:0] data);
    @(posedge clk_i); #1;
    wr_en_i = 1'b1; wr_addr_i = 4'(addr); wr_data_i = data;
    @(posedge clk_i); #1;
    wr_en_i = 1'b0;
    chart_m[addr] = data;
  endtask

  task automatic fill_frames(input int pct);
    for (int c = 0; c < 512; c++) frame_tab[c] = ($urandom_range(0, 99) < pct);
  endtask

  // Builds the expected launch timeline, then plays it cycle by cycle.
  task automatic run_playback(input string name, input int n, input bit noise);
    int f, l, fire, cnt, done_at, idx;
    logic [11:0] e;
    logic [3:0]  exp_launch, exp_idx;
    bit finished, is_launch;
    exp_q.delete();
    done_at = 1 << 30; f = 1; idx = 0; finished = 0;
    while (!finished && f < n) begin
      l = f + 1;
      e = chart_m[idx];
      if (e == 12'd0) begin
`ifdef ARROW_SCHEDULER_LOOP_EN
        if (idx != 0) begin
          idx = 0; f = l + 1;
        end else begin
          done_at = l + 1; finished = 1;
        end
`else
        done_at = l + 1; finished = 1;
`endif
      end else begin
        if (e[11:4] == 8'd0) begin
          fire = l + 1;
        end else begin
          cnt = 0; fire = n;
          for (int c = l + 1; c < n; c++) begin
            if (frame_tab[c]) begin
              cnt++;
              if (cnt == int'(e[11:4])) begin
                fire = c + 1;
                break;
              end
            end
          end
        end
        if (fire >= n) begin
          finished = 1;
        end else begin
          exp_q.push_back({16'(fire), 4'(idx), e[3:0]});
          if (idx == DEPTH - 1) begin
`ifdef ARROW_SCHEDULER_LOOP_EN
            idx = 0; f = fire + 1;
`else
            done_at = fire + 1; finished = 1;
`endif
          end else begin
            idx++; f = fire + 1;
          end
        end
      end
    end

    @(posedge clk_i); #1;
    start_i = 1'b1; frame_i = frame_tab[0];
    for (int c = 1; c < n; c++) begin
      @(posedge clk_i); #1;
      start_i = noise && (c < done_at) && ($urandom_range(0, 9) == 0);
      frame_i = frame_tab[c];
      @(negedge clk_i);
      is_launch  = (exp_q.size() > 0) && (int'(exp_q[0][23:8]) == c);
      exp_launch = 4'b0000;
      exp_idx    = 4'd0;
      if (is_launch) begin
        exp_launch = exp_q[0][3:0];
        exp_idx    = exp_q[0][7:4];
        void'(exp_q.pop_front());
      end
      n_checks++;
      if (launch_o !== exp_launch) begin
        n_fail++;
        $display("FAIL %s launch cycle %0d: got %b expected %b", name, c, launch_o, exp_launch);
      end
      if (is_launch) begin
        n_checks++;
        if (idx_o !== exp_idx) begin
          n_fail++;
          $display("FAIL %s idx cycle %0d: got %0d expected %0d", name, c, idx_o, exp_idx);
        end
      end
      n_checks++;
      if (busy_o !== (c < done_at) || done_o !== (c >= done_at)) begin
        n_fail++;
        $display("FAIL %s busy/done cycle %0d: got %b/%b expected %b/%b", name, c,
                 busy_o, done_o, (c < done_at), (c >= done_at));
      end
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; frame_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1; frame_i = 0; start_i = 0; stop_i = 0; wr_en_i = 0;
    wr_addr_i = '0; wr_data_i = '0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (launch_o !== 4'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || idx_o !== 4'd0 ||
        state_dbg_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: got launch=%b busy=%b done=%b idx=%0d state=%0d expected all 0",
               launch_o, busy_o, done_o, idx_o, state_dbg_o);
    end
    rst_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_entry(i, 12'd0);
  endtask

  task automatic test_single_fire();
    write_entry(0, {8'd0, 4'b0001});
    write_entry(1, 12'd0);
    fill_frames(30);
    run_playback("single_fire", 12, 1'b0);
  endtask

  task automatic test_delay_three();
    write_entry(0, {8'd3, 4'b1010});
    write_entry(1, 12'd0);
    for (int c = 0; c < 512; c++) frame_tab[c] = 1'b0;
    frame_tab[1] = 1'b1;  // lands in FETCH, must be ignored
    frame_tab[5] = 1'b1; frame_tab[9] = 1'b1; frame_tab[14] = 1'b1;
    run_playback("delay_three", 24, 1'b0);
  endtask

  task automatic test_random_charts();
    int len, d;
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        d = $urandom_range(0, 3);
        if (i == len) write_entry(i, 12'd0);
        else write_entry(i, {8'(d), (d == 0) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15))});
      end
      fill_frames(40);
      run_playback("random_chart", 400, 1'b1);
    end
  endtask

  task automatic test_full_chart();
    for (int i = 0; i < DEPTH; i++) write_entry(i, {8'd1, 4'($urandom_range(1, 15))});
    fill_frames(100);
    run_playback("full_chart", 120, 1'b0);
  endtask

  task automatic test_stop_wait();
    write_entry(0, {8'd5, 4'b0100});
    write_entry(1, 12'd0);
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(posedge clk_i); #1;
    repeat (3) begin @(posedge clk_i); #1 frame_i = 1'b1; end
    @(posedge clk_i); #1 frame_i = 1'b0; stop_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b1 || launch_o !== 4'd0) begin
      n_fail++;
      $display("FAIL stop_wait_pre: got busy=%b launch=%b expected 1/0000", busy_o, launch_o);
    end
    @(posedge clk_i); #1 stop_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || idx_o !== 4'd0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_wait_idle: got busy=%b idx=%0d done=%b expected 0/0/0", busy_o, idx_o, done_o);
    end
    repeat (10) begin
      @(posedge clk_i); #1 frame_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (launch_o !== 4'd0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_wait_after: got launch=%b busy=%b expected 0000/0", launch_o, busy_o);
      end
    end
    @(posedge clk_i); #1 frame_i = 1'b0;
  endtask

  task automatic test_reset_in_fire();
    write_entry(0, {8'd0, 4'b0110});
    write_entry(1, 12'd0);
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (launch_o !== 4'b0110) begin
      n_fail++;
      $display("FAIL fire_before_reset: got %b expected 0110", launch_o);
    end
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if (launch_o !== 4'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || idx_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_in_fire: got launch=%b busy=%b done=%b idx=%0d expected all 0",
               launch_o, busy_o, done_o, idx_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
    fill_frames(50);
    run_playback("replay_after_reset", 12, 1'b0);
  endtask

  task automatic test_start_stop_same_cycle();
    @(posedge clk_i); #1 stop_i = 1'b1;
    @(posedge clk_i); #1 stop_i = 1'b0;
    @(posedge clk_i); #1 start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0; stop_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      n_checks++;
      if (busy_o !== 1'b0 || launch_o !== 4'd0 || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL start_stop_same_cycle: got busy=%b launch=%b done=%b expected 0/0000/0",
                 busy_o, launch_o, done_o);
      end
      @(posedge clk_i); #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_fire();
    test_delay_three();
    test_random_charts();
    test_stop_wait();
    test_reset_in_fire();
    test_full_chart();
    test_start_stop_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arrow_scheduler.md
ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

Interface
REQ-001 SHALL have parameter CHART_DEPTH, default 16, number of chart entries (power of two, >=2).
REQ-002 SHALL have parameter DELAYW, default 8, width of per-entry frame delay.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port frame_i  input  1  one-cycle pulse per video frame.
REQ-006 SHALL have port start_i  input  1  begin chart playback from entry 0.
REQ-007 SHALL have port stop_i  input  1  abort playback, return to idle.
REQ-008 SHALL have port wr_en_i  input  1  chart write strobe.
REQ-009 SHALL have port wr_addr_i  input  $clog2(CHART_DEPTH)  chart write address.
REQ-010 SHALL have port wr_data_i  input  DELAYW+4  entry: [DELAYW+3:4] frame delay, [3:0] lane mask.
REQ-011 SHALL have port launch_o  output  4  one-cycle launch pulses, bit0 left, bit1 up, bit2 down, bit3 right; drives the four arrow-movement launch inputs.
REQ-012 SHALL have ports busy_o (1, playback active), done_o (1, chart finished), idx_o ($clog2(CHART_DEPTH), current entry).

Function
REQ-013 SHALL store chart in internal CHART_DEPTH x (DELAYW+4) memory, written when wr_en_i=1 in any state; read is registered, read-before-write on same-address collision.
REQ-014 SHALL treat entry with delay=0 and mask=0 as end marker.
REQ-015 SHALL implement states IDLE, FETCH, LOAD, WAIT, FIRE, DONE; busy_o=1 in FETCH/LOAD/WAIT/FIRE only.
REQ-016 IDLE or DONE: start_i=1 -> idx<=0, done_o<=0, FETCH; otherwise hold.
REQ-017 FETCH: present idx to memory -> LOAD next cycle.
REQ-018 LOAD: end marker -> end-of-chart handling (REQ-022); delay=0 -> FIRE; else load counter with delay -> WAIT.
REQ-019 WAIT: each frame_i pulse decrements counter; cycle after the pulse bringing counter to 0 -> FIRE; frame_i ignored in all other states.
REQ-020 FIRE: launch_o=mask for exactly that cycle, 0 otherwise; then idx==CHART_DEPTH-1 -> end-of-chart handling, else idx<=idx+1, FETCH.
REQ-021 Latency: start_i in cycle T with entry 0 delay=0 -> launch_o high in cycle T+3 only.
REQ-022 End of chart (no macro): done_o<=1, busy_o<=0, state DONE; done_o held until start_i or stop_i.
REQ-023 stop_i=1 in any state -> IDLE next cycle, launch_o=0, done_o<=0, idx<=0; stop_i beats simultaneous start_i.
REQ-024 start_i while busy SHALL be ignored.

Reset
REQ-025 rst_i=1 SHALL immediately force IDLE, launch_o=0, busy_o=0, done_o=0, idx_o=0, counter=0, including mid-WAIT or mid-FIRE.
REQ-026 Chart memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With ARROW_SCHEDULER_LOOP_EN defined, end of chart SHALL set idx<=0 and go to FETCH without asserting done_o; if entry 0 is itself end marker, REQ-022 applies (no infinite spin).
REQ-028 Without ARROW_SCHEDULER_LOOP_EN, REQ-022 SHALL apply at every end of chart.

Verification
REQ-029 Entry0={delay 0, mask 4'b0001}, entry1=end; start_i in cycle T -> launch_o=0001 in T+3 only, done_o=1 from T+6, busy_o=0.
REQ-030 Entry0={delay 3, mask 4'b1010}; start, three frame_i pulses -> launch_o=1010 exactly one cycle after third pulse, none earlier.
REQ-031 stop_i during WAIT with counter=2 -> IDLE next cycle, no launch on later frame_i, idx_o=0.
REQ-032 rst_i asserted in FIRE cycle -> launch_o drops to 0 asynchronously, all outputs at reset values; chart replays identically after new start_i.
REQ-033 All 16 entries non-marker, delay 1 -> 16 launches, then done_o=1 (no macro) or launch of entry 0 again with done_o=0 (ARROW_SCHEDULER_LOOP_EN).
REQ-034 start_i and stop_i high in the same cycle from IDLE -> stays IDLE, busy_o=0.
